// File: rtl/int_sequencer.sv
// Interrupt entry sequencer: accepts a pending interrupt at an instruction
// boundary, grants it, waits for the context save, then issues the vector.
// Tracks in-service sources so that only strictly higher priority can nest.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for an acceptable break; honours eret
// ST_GRANT  | one-cycle grant pulse to the winning source
// ST_SAVE   | context save requested, waiting for save_ack
// ST_VECTOR | one-cycle take pulse with the vector address
module int_sequencer #(
   parameter logic [7:0] VEC_BASE   = 8'h40,
   parameter int         VEC_STRIDE = 4
) (
   input  logic       in_CLK,
   input  logic       in_RST_N,
   input  logic       in_break,
   input  logic [1:0] in_code,
   input  logic       in_boundary,
   input  logic       in_eret,
   input  logic       in_save_ack,
   input  logic       in_ie_set,
   input  logic       in_ie_clr,
   input  logic [3:0] in_swmask,
   output logic [3:0] out_IG,
   output logic [3:0] out_INM,
   output logic       out_IE,
   output logic       out_save_req,
   output logic       out_take,
   output logic [7:0] out_vector,
   output logic [3:0] out_isr,
   output logic       out_busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_SAVE   = 2'd2,
      ST_VECTOR = 2'd3
   } state_t;

   localparam logic [7:0] STRIDE8 = 8'(VEC_STRIDE);

   state_t     state_q, state_d;
   logic [1:0] code_q, code_d;
   logic [3:0] isr_q, isr_d;
   logic [3:0] ig_q, ig_d;
   logic       ie_q, ie_d;
   logic       save_req_q, save_req_d;
   logic       take_q, take_d;
   logic       busy_q, busy_d;
   logic [7:0] vector_q, vector_d;
   logic [7:0] vec_calc;

   // Return from interrupt retires the highest-priority in-service source.
   function automatic logic [3:0] clr_top(input logic [3:0] v);
      logic [3:0] r;
      r = v;
      if (v[3])      r[3] = 1'b0;
      else if (v[2]) r[2] = 1'b0;
      else if (v[1]) r[1] = 1'b0;
      else if (v[0]) r[0] = 1'b0;
      return r;
   endfunction

   // Next state, latched code and in-service register.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      isr_d   = isr_q;
      case (state_q)
         ST_IDLE: begin
            // eret takes precedence; a coincident break is looked at again next cycle
            if (in_eret) begin
               isr_d = clr_top(isr_q);
            end else if (in_break && in_boundary) begin
               state_d = ST_GRANT;
               code_d  = in_code;
            end
         end
         ST_GRANT: begin
            isr_d   = isr_q | (4'b0001 << code_q);
            state_d = ST_SAVE;
         end
         ST_SAVE: begin
            if (in_save_ack) state_d = ST_VECTOR;
         end
         ST_VECTOR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, derived from the next state so
   // that every output is a flop.
   always_comb begin
      vec_calc   = VEC_BASE + 8'(code_q) * STRIDE8;
      ig_d       = (state_d == ST_GRANT) ? (4'b0001 << code_d) : 4'b0000;
      save_req_d = (state_d == ST_SAVE);
      take_d     = (state_d == ST_VECTOR);
      busy_d     = (state_d != ST_IDLE);
      vector_d   = (state_d == ST_VECTOR) ? vec_calc : vector_q;
      if (in_ie_clr)      ie_d = 1'b0;
      else if (in_ie_set) ie_d = 1'b1;
      else                ie_d = ie_q;
   end

   // Effective mask: a source is blocked if masked by software or if it or
   // any higher-priority source is in service.
   always_comb begin
      out_INM = in_swmask;
      for (int i = 0; i < 4; i++) begin
         out_INM[i] = in_swmask[i] | (|(isr_q >> i));
      end
   end

   // State and registered outputs.
   always_ff @(posedge in_CLK or negedge in_RST_N) begin
      if (!in_RST_N) begin
         state_q    <= ST_IDLE;
         code_q     <= 2'd0;
         isr_q      <= 4'd0;
         ig_q       <= 4'd0;
         ie_q       <= 1'b0;
         save_req_q <= 1'b0;
         take_q     <= 1'b0;
         busy_q     <= 1'b0;
         vector_q   <= VEC_BASE;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         isr_q      <= isr_d;
         ig_q       <= ig_d;
         ie_q       <= ie_d;
         save_req_q <= save_req_d;
         take_q     <= take_d;
         busy_q     <= busy_d;
         vector_q   <= vector_d;
      end
   end

   assign out_IG       = ig_q;
   assign out_IE       = ie_q;
   assign out_save_req = save_req_q;
   assign out_take     = take_q;
   assign out_vector   = vector_q;
   assign out_isr      = isr_q;
   assign out_busy     = busy_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer with hand-computed expectations.
module tb_int_sequencer;

   logic       in_CLK = 1'b0;
   logic       in_RST_N;
   logic       in_break, in_boundary, in_eret, in_save_ack, in_ie_set, in_ie_clr;
   logic [1:0] in_code;
   logic [3:0] in_swmask;
   logic [3:0] out_IG, out_INM, out_isr;
   logic       out_IE, out_save_req, out_take, out_busy;
   logic [7:0] out_vector;

   int n_tests = 0;
   int n_fail  = 0;

   int_sequencer dut (
      .in_CLK      (in_CLK),
      .in_RST_N    (in_RST_N),
      .in_break    (in_break),
      .in_code     (in_code),
      .in_boundary (in_boundary),
      .in_eret     (in_eret),
      .in_save_ack (in_save_ack),
      .in_ie_set   (in_ie_set),
      .in_ie_clr   (in_ie_clr),
      .in_swmask   (in_swmask),
      .out_IG      (out_IG),
      .out_INM     (out_INM),
      .out_IE      (out_IE),
      .out_save_req(out_save_req),
      .out_take    (out_take),
      .out_vector  (out_vector),
      .out_isr     (out_isr),
      .out_busy    (out_busy)
   );

   always #5 in_CLK = ~in_CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: sim time expired, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge in_CLK);
      #1;
   endtask

   logic bad;

   initial begin
      in_RST_N = 1'b0; in_break = 0; in_code = 0; in_boundary = 0; in_eret = 0;
      in_save_ack = 0; in_ie_set = 0; in_ie_clr = 0; in_swmask = 4'b0000;
      #12;
      check_eq("rst_vector", out_vector, 8'h40);
      check_eq("rst_flags", {out_IG, out_IE, out_save_req, out_take, out_busy}, 8'h00);
      check_eq("rst_isr_inm", {out_isr, out_INM}, 8'h00);
      #6 in_RST_N = 1'b1;

      // Basic entry, code 2, ack already high
      in_ie_set = 1; tick(); in_ie_set = 0;
      check_eq("ie_set", out_IE, 1);
      in_break = 1; in_code = 2; in_boundary = 1; in_save_ack = 1;
      tick();
      check_eq("t1_grant", out_IG, 4'b0100);
      check_eq("t1_busy", out_busy, 1);
      in_break = 0; in_code = 0;  // changes after acceptance must not matter
      tick();
      check_eq("t1_save", {out_IG, out_save_req, out_take}, {4'b0000, 1'b1, 1'b0});
      check_eq("t1_isr", out_isr, 4'b0100);
      check_eq("t1_inm", out_INM, 4'b0111);
      tick();
      check_eq("t1_take", {out_take, out_save_req}, 2'b10);
      check_eq("t1_vector", out_vector, 8'h48);
      tick();
      check_eq("t1_idle", {out_take, out_busy}, 2'b00);
      check_eq("t1_vec_hold", out_vector, 8'h48);

      // Nested higher-priority entry, then two erets
      in_break = 1; in_code = 3;
      tick();
      check_eq("t2_grant", out_IG, 4'b1000);
      in_break = 0;
      tick();
      check_eq("t2_isr", out_isr, 4'b1100);
      check_eq("t2_inm", out_INM, 4'b1111);
      tick();
      check_eq("t2_take", out_take, 1);
      check_eq("t2_vector", out_vector, 8'h4C);
      tick();
      in_eret = 1; tick(); in_eret = 0;
      check_eq("t2_eret1", out_isr, 4'b0100);
      in_eret = 1; tick();
      check_eq("t2_eret2", out_isr, 4'b0000);
      tick(); in_eret = 0;
      check_eq("t2_eret_empty", out_isr, 4'b0000);

      // Save stalls while ack is low; eret during the stall is dropped
      in_save_ack = 0; in_break = 1; in_code = 1;
      tick(); in_break = 0;
      tick();
      in_eret = 1;
      for (int k = 0; k < 5; k++) begin
         check_eq($sformatf("t3_stall%0d", k), {out_save_req, out_busy, out_take}, 3'b110);
         tick();
         in_eret = 0;
      end
      check_eq("t3_eret_dropped", out_isr, 4'b0010);
      in_save_ack = 1;
      tick();
      check_eq("t3_take", out_take, 1);
      check_eq("t3_vector", out_vector, 8'h44);
      tick();
      in_swmask = 4'b0100;
      #1 check_eq("t3_inm_mix", out_INM, 4'b0111);
      in_swmask = 4'b0000;

      // eret and break together: eret wins, accept next cycle
      in_eret = 1; in_break = 1; in_code = 0;
      tick(); in_eret = 0;
      check_eq("t4_eret_first", {out_isr, out_busy, out_IG}, {4'b0000, 1'b0, 4'b0000});
      tick(); in_break = 0;
      check_eq("t4_grant", out_IG, 4'b0001);
      tick(); tick();
      check_eq("t4_take", {out_take, out_vector}, {1'b1, 8'h40});
      tick();
      in_eret = 1; tick(); in_eret = 0;
      check_eq("t4_isr_clr", out_isr, 4'b0000);
      in_boundary = 0; in_break = 1; in_code = 3;
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (out_busy || out_IG != 0) bad = 1;
      end
      check_eq("t4_no_boundary", bad, 0);
      in_break = 0; in_boundary = 1;

      // Reset during SAVE
      in_save_ack = 0; in_break = 1; in_code = 3;
      tick(); in_break = 0;
      tick();
      check_eq("t5_in_save", out_save_req, 1);
      #2 in_RST_N = 0;
      #1;
      check_eq("t5_async_flags", {out_IG, out_IE, out_save_req, out_take, out_busy}, 8'h00);
      check_eq("t5_async_state", {out_isr, out_vector}, {4'b0000, 8'h40});
      in_save_ack = 1;
      tick();
      #2 in_RST_N = 1;
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (out_take || out_busy || out_save_req) bad = 1;
      end
      check_eq("t5_no_take", bad, 0);

      // Enable register and software mask
      in_ie_set = 1; in_ie_clr = 1; tick();
      check_eq("t6_both_from0", out_IE, 0);
      in_ie_clr = 0; tick();
      check_eq("t6_set", out_IE, 1);
      in_ie_clr = 1; tick(); in_ie_set = 0; in_ie_clr = 0;
      check_eq("t6_both_from1", out_IE, 0);
      tick();
      check_eq("t6_hold", out_IE, 0);
      in_swmask = 4'b1000;
      #1 check_eq("t6_swmask", out_INM, 4'b1000);
      in_swmask = 4'b0000;

      // First edge after reset release can accept
      in_RST_N = 0;
      #3 in_break = 1; in_code = 1; in_boundary = 1;
      #3 in_RST_N = 1;
      tick(); in_break = 0;
      check_eq("t7_first_edge", out_IG, 4'b0010);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/int_sequencer.md
INT_SEQUENCER -- requirements
Module: int_sequencer

Interface
REQ-001 Parameter VEC_BASE, default 8'h40, is the base address of the interrupt vector table.
REQ-002 Parameter VEC_STRIDE, default 4, is the vector spacing per interrupt code.
REQ-003 Port in_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port in_RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_break, input, 1: an unmasked pending interrupt exists and global enable is set.
REQ-006 Port in_code, input, 2: priority-encoded winning source, 3 = highest.
REQ-007 Port in_boundary, input, 1: the CPU is at an instruction boundary this cycle.
REQ-008 Port in_eret, input, 1: one-cycle pulse when a return-from-interrupt retires.
REQ-009 Port in_save_ack, input, 1: the context-save memory path has completed.
REQ-010 Port in_ie_set, input, 1: pulse that sets global enable.
REQ-011 Port in_ie_clr, input, 1: pulse that clears global enable.
REQ-012 Port in_swmask, input, 4: software per-source mask, 1 = masked.
REQ-013 Port out_IG, output, 4: one-hot, one-cycle grant pulse that clears the serviced request flag.
REQ-014 Port out_INM, output, 4: effective mask fed back to the interrupt unit.
REQ-015 Port out_IE, output, 1: global interrupt enable register.
REQ-016 Port out_save_req, output, 1: request to save context.
REQ-017 Port out_take, output, 1: one-cycle pulse that loads PC from out_vector.
REQ-018 Port out_vector, output, 8: vector address.
REQ-019 Port out_isr, output, 4: in-service register.
REQ-020 Port out_busy, output, 1: high whenever the state is not IDLE.

Function
REQ-021 FSM states are IDLE, GRANT, SAVE and VECTOR, each registered.
REQ-022 IDLE->GRANT when in_break=1, in_boundary=1 and in_eret=0; latch in_code into code_q in that cycle.
REQ-023 GRANT lasts exactly 1 cycle: out_IG[code_q]=1, isr[code_q] set at the exit edge, then ->SAVE.
REQ-024 SAVE holds out_save_req=1 until in_save_ack=1 is sampled, then ->VECTOR; minimum dwell is 1 cycle, with no timeout.
REQ-025 in_save_ack sampled in any state other than SAVE is ignored.
REQ-026 VECTOR lasts 1 cycle: out_take=1, out_vector = (VEC_BASE + code_q*VEC_STRIDE) mod 256, then ->IDLE.
REQ-027 out_vector is registered, holds its last value outside VECTOR, and resets to VEC_BASE.
REQ-028 Latency from the accepting IDLE cycle to out_take is 3 cycles when in_save_ack is already high on SAVE entry.
REQ-029 out_INM[i] = in_swmask[i] OR (isr[j]=1 for any j>=i): this blocks same-or-lower priority sources, so only strictly higher priority can nest.
REQ-030 out_INM is combinational from isr and in_swmask.
REQ-031 in_eret is honoured only in IDLE: it clears the highest set isr bit, and with isr=0 it does nothing.
REQ-032 in_eret in a non-IDLE state is dropped.
REQ-033 in_eret and in_break in the same IDLE cycle: the eret is applied and the break is re-evaluated on the next cycle.
REQ-034 out_IE: set by in_ie_set, cleared by in_ie_clr; simultaneous pulses give clr wins; it is held otherwise.
REQ-035 out_IE is NOT changed automatically on entry; nesting is governed by isr.
REQ-036 A change of in_break or in_code after acceptance does not affect the sequence in progress.
REQ-037 Nesting depth is bounded by 4, one isr bit per source, so no overflow is possible.

Reset
REQ-038 While in_RST_N=0: state=IDLE, isr=0, code_q=0, out_IE=0, out_vector=VEC_BASE, and out_IG, out_save_req, out_take and out_busy are 0.
REQ-039 Reset asserted mid-sequence aborts immediately, with no grant, take or save pulse afterwards.
REQ-040 The first transition out of IDLE is possible on the first rising edge after in_RST_N=1.

Verification
REQ-041 ie_set, break=1, code=2, boundary=1, save_ack tied 1 -> IG=0100 next cycle, take=1 with vector=8'h48 three cycles after accept, isr=0100, INM=0111.
REQ-042 With isr=0100, code=3 break -> accepted, vector=8'h4C, isr=1100; then eret -> isr=0100; second eret -> isr=0000.
REQ-043 save_ack held 0 for 5 cycles in SAVE -> save_req=1 and busy=1 throughout, no take; ack=1 -> take on the following cycle.
REQ-044 eret and break together in IDLE -> eret applied, accept on next cycle; in_boundary=0 -> break never accepted.
REQ-045 in_RST_N=0 during SAVE -> all outputs go to reset values asynchronously, and no take after release.
REQ-046 ie_set and ie_clr in the same cycle -> IE=0; swmask=1000 with isr=0 -> INM=1000.
